// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: resolves the next fetch address from EX-stage control,
// squashes the front of the pipe on redirects and sequences ecall/fence drain and ebreak halt.
//
// state | meaning
// RUN   | normal fetch; EX events evaluated when ex_valid=1
// DRAIN | ecall/fence serialisation, fetch suppressed for DRAIN_CYCLES
// HALT  | ebreak or misaligned target, pc frozen until resume
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic [1:0]  ex_srcPC,
    input  logic        ex_pcload,
    input  logic        ex_cond,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_alu_result,
    input  logic        stall,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        halted,
    output logic        misalign
);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic        halted_q, halted_d;
    logic        misalign_q, misalign_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        ev;
    logic        taken;
    logic        serialise;
    logic        flush;
    logic [31:0] target;

    always_comb begin
        ev        = (state_q == RUN) && ex_valid;
        taken     = (ex_branch & ex_cond) | ex_jump;
        serialise = (ex_srcPC == 2'b11);
        target    = (ex_srcPC == 2'b10) ? (ex_alu_result & ~32'h1) : (ex_pc + ex_imm);
        flush     = ev && (ex_pcload || serialise || taken);

        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        halted_d   = halted_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;

        case (state_q)
            RUN: begin
                if_valid_d = 1'b1;
                if (ev && ex_pcload) begin
                    pc_d       = ex_pc;
                    state_d    = HALT;
                    halted_d   = 1'b1;
                    if_valid_d = 1'b0;
                end else if (ev && serialise) begin
                    pc_d       = ex_pc + 32'd4;
                    cnt_d      = DRAIN_INIT;
                    state_d    = DRAIN;
                    if_valid_d = 1'b0;
                end else if (ev && taken) begin
                    if (target[1]) begin
                        pc_d       = ex_pc;
                        state_d    = HALT;
                        halted_d   = 1'b1;
                        misalign_d = 1'b1;
                        if_valid_d = 1'b0;
                    end else begin
                        pc_d = target;
                    end
                // the first cycle out of reset fetches RESET_PC itself
                end else if (!stall && if_valid_q) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            DRAIN: begin
                if_valid_d = 1'b0;
                cnt_d      = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d      = 4'd0;
                    state_d    = RUN;
                    if_valid_d = 1'b1;
                end
            end
            HALT: begin
                if_valid_d = 1'b0;
                if (resume) begin
                    pc_d       = pc_q + 32'd4;
                    state_d    = RUN;
                    halted_d   = 1'b0;
                    misalign_d = 1'b0;
                    if_valid_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc         = pc_q;
    assign if_valid   = if_valid_q;
    assign halted     = halted_q;
    assign misalign   = misalign_q;
    assign flush_ifid = flush;
    assign flush_idex = flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, branches, jalr, fence drain, ebreak halt, wrap.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_branch, ex_jump, ex_pcload, ex_cond;
    logic [1:0]  ex_srcPC;
    logic [31:0] ex_pc, ex_imm, ex_alu_result;
    logic        stall, resume;
    logic [31:0] pc;
    logic        if_valid, flush_ifid, flush_idex, halted, misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_srcPC(ex_srcPC), .ex_pcload(ex_pcload), .ex_cond(ex_cond),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
        .stall(stall), .resume(resume),
        .pc(pc), .if_valid(if_valid), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .halted(halted), .misalign(misalign)
    );

    task automatic clear_ex();
        ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_pcload = 0; ex_cond = 0;
        ex_srcPC = 2'b00; ex_pc = 0; ex_imm = 0; ex_alu_result = 0; stall = 0; resume = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_ex();
        #12;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
        total++; if ({if_valid, halted, misalign} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {if_valid, halted, misalign}); end
        total++; if ({flush_ifid, flush_idex} !== 2'b00) begin bad++; $display("FAIL reset_flush got=%b exp=00", {flush_ifid, flush_idex}); end
        @(negedge clk);
        rst_n = 1;
        step();
        total++; if (pc !== 32'h0 || if_valid !== 1'b1) begin bad++; $display("FAIL first_fetch pc=%h v=%b exp pc=0 v=1", pc, if_valid); end
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (pc !== 32'(4 * i) || if_valid !== 1'b1 || flush_ifid !== 1'b0) begin
                bad++; $display("FAIL seq_%0d pc=%h v=%b fl=%b exp pc=%h v=1 fl=0", i, pc, if_valid, flush_ifid, 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch();
        ex_valid = 1; ex_branch = 1; ex_cond = 1; ex_srcPC = 2'b01;
        ex_pc = 32'h40; ex_imm = 32'h20; stall = 1;
        #1;
        total++; if ({flush_ifid, flush_idex} !== 2'b11) begin bad++; $display("FAIL beq_flush got=%b exp=11", {flush_ifid, flush_idex}); end
        step();
        clear_ex();
        #1;
        total++; if (pc !== 32'h60 || {flush_ifid, flush_idex} !== 2'b00) begin bad++; $display("FAIL beq_target pc=%h fl=%b exp pc=60 fl=00", pc, {flush_ifid, flush_idex}); end
        ex_valid = 1; ex_branch = 1; ex_cond = 0; ex_srcPC = 2'b01; ex_pc = 32'h40; ex_imm = 32'h20;
        #1;
        total++; if (flush_ifid !== 1'b0) begin bad++; $display("FAIL bne_flush got=%b exp=0", flush_ifid); end
        step();
        total++; if (pc !== 32'h64) begin bad++; $display("FAIL bne_seq pc=%h exp=64", pc); end
        stall = 1;
        step();
        total++; if (pc !== 32'h64 || if_valid !== 1'b1 || flush_idex !== 1'b0) begin bad++; $display("FAIL stall_hold pc=%h v=%b fl=%b exp pc=64 v=1 fl=0", pc, if_valid, flush_idex); end
        clear_ex();
    endtask

    task automatic test_jalr();
        ex_valid = 1; ex_jump = 1; ex_srcPC = 2'b10; ex_pc = 32'h70; ex_alu_result = 32'h101;
        #1;
        total++; if ({flush_ifid, flush_idex} !== 2'b11) begin bad++; $display("FAIL jalr_flush got=%b exp=11", {flush_ifid, flush_idex}); end
        step();
        total++; if (pc !== 32'h100 || halted !== 1'b0) begin bad++; $display("FAIL jalr_target pc=%h h=%b exp pc=100 h=0", pc, halted); end
        ex_pc = 32'h100; ex_alu_result = 32'h102;
        #1;
        total++; if ({flush_ifid, flush_idex} !== 2'b11) begin bad++; $display("FAIL misal_flush got=%b exp=11", {flush_ifid, flush_idex}); end
        step();
        clear_ex();
        #1;
        total++; if (pc !== 32'h100 || {halted, misalign, if_valid} !== 3'b110) begin
            bad++; $display("FAIL misal_halt pc=%h hmv=%b exp pc=100 hmv=110", pc, {halted, misalign, if_valid});
        end
        resume = 1;
        step();
        resume = 0;
        total++; if (pc !== 32'h104 || {halted, misalign, if_valid} !== 3'b001) begin
            bad++; $display("FAIL misal_resume pc=%h hmv=%b exp pc=104 hmv=001", pc, {halted, misalign, if_valid});
        end
    endtask

    task automatic test_fence();
        ex_valid = 1; ex_srcPC = 2'b11; ex_pc = 32'h80;
        #1;
        total++; if ({flush_ifid, flush_idex} !== 2'b11) begin bad++; $display("FAIL fence_flush got=%b exp=11", {flush_ifid, flush_idex}); end
        step();
        ex_srcPC = 2'b01; ex_jump = 1; ex_pc = 32'h300; ex_imm = 32'h0; resume = 1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            total++; if (if_valid !== 1'b0 || pc !== 32'h84 || flush_ifid !== 1'b0) begin
                bad++; $display("FAIL drain_%0d v=%b pc=%h fl=%b exp v=0 pc=84 fl=0", i, if_valid, pc, flush_ifid);
            end
            if (i == 3) clear_ex();
            step();
        end
        total++; if (if_valid !== 1'b1 || pc !== 32'h84) begin bad++; $display("FAIL drain_exit v=%b pc=%h exp v=1 pc=84", if_valid, pc); end
    endtask

    task automatic test_ebreak();
        ex_valid = 1; ex_pcload = 1; ex_pc = 32'h200;
        #1;
        total++; if ({flush_ifid, flush_idex} !== 2'b11) begin bad++; $display("FAIL ebreak_flush got=%b exp=11", {flush_ifid, flush_idex}); end
        step();
        ex_pcload = 0; ex_jump = 1; ex_srcPC = 2'b01; ex_pc = 32'h500; ex_imm = 32'h4;
        for (int i = 0; i < 10; i++) begin
            total++; if (pc !== 32'h200 || halted !== 1'b1 || if_valid !== 1'b0 || flush_ifid !== 1'b0) begin
                bad++; $display("FAIL halt_%0d pc=%h h=%b v=%b fl=%b exp pc=200 h=1 v=0 fl=0", i, pc, halted, if_valid, flush_ifid);
            end
            step();
        end
        clear_ex();
        resume = 1;
        step();
        resume = 0;
        total++; if (pc !== 32'h204 || {halted, misalign, if_valid} !== 3'b001) begin
            bad++; $display("FAIL ebreak_resume pc=%h hmv=%b exp pc=204 hmv=001", pc, {halted, misalign, if_valid});
        end
    endtask

    task automatic test_wrap_reset();
        ex_valid = 1; ex_jump = 1; ex_srcPC = 2'b00; ex_pc = 32'h0; ex_imm = 32'hFFFF_FFFC;
        step();
        clear_ex();
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup pc=%h exp=fffffffc", pc); end
        step();
        total++; if (pc !== 32'h0 || if_valid !== 1'b1) begin bad++; $display("FAIL wrap pc=%h v=%b exp pc=0 v=1", pc, if_valid); end
        ex_valid = 1; ex_jump = 1; ex_srcPC = 2'b10; ex_pc = 32'h10; ex_alu_result = 32'h42;
        step();
        clear_ex();
        total++; if ({halted, misalign} !== 2'b11 || pc !== 32'h10) begin bad++; $display("FAIL pre_reset hm=%b pc=%h exp hm=11 pc=10", {halted, misalign}, pc); end
        #2;
        rst_n = 0;
        #1;
        total++; if (pc !== 32'h0 || {halted, misalign, if_valid} !== 3'b000) begin
            bad++; $display("FAIL async_reset pc=%h hmv=%b exp pc=0 hmv=000", pc, {halted, misalign, if_valid});
        end
        @(negedge clk);
        rst_n = 1;
        step();
        step();
        total++; if (pc !== 32'h4 || if_valid !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL post_reset pc=%h v=%b h=%b exp pc=4 v=1 h=0", pc, if_valid, halted); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jalr();
        test_fence();
        test_ebreak();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
